// File: rtl/card_compare.sv
// rtl/card_compare.sv - registered two-player card comparator with saturating outcome tallies
module card_compare #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       p1_handcard,
    input  logic [3:0]       p2_handcard,
    output logic [1:0]       matchresult,
    output logic             result_valid,
    output logic [CNT_W-1:0] p1_wins,
    output logic [CNT_W-1:0] p2_wins,
    output logic [CNT_W-1:0] draws
);

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_DRAW = 2'b01;
    localparam logic [1:0] RES_P1   = 2'b10;
    localparam logic [1:0] RES_P2   = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       r_matchresult;
    logic             r_result_valid;
    logic [CNT_W-1:0] r_p1_wins;
    logic [CNT_W-1:0] r_p2_wins;
    logic [CNT_W-1:0] r_draws;

    logic [1:0]       w_outcome;

    always_comb begin
        w_outcome = RES_DRAW;
        if (p1_handcard > p2_handcard) begin
            w_outcome = RES_P1;
        end else if (p1_handcard < p2_handcard) begin
            w_outcome = RES_P2;
        end
    end

    // Card values are only looked at under in_valid, so idle-cycle garbage never reaches state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_matchresult  <= RES_NONE;
            r_result_valid <= 1'b0;
            r_p1_wins      <= '0;
            r_p2_wins      <= '0;
            r_draws        <= '0;
        end else begin
            r_result_valid <= in_valid;
            if (in_valid) begin
                r_matchresult <= w_outcome;
                if (w_outcome == RES_P1 && r_p1_wins != CNT_MAX) begin
                    r_p1_wins <= r_p1_wins + 1'b1;
                end
                if (w_outcome == RES_P2 && r_p2_wins != CNT_MAX) begin
                    r_p2_wins <= r_p2_wins + 1'b1;
                end
                if (w_outcome == RES_DRAW && r_draws != CNT_MAX) begin
                    r_draws <= r_draws + 1'b1;
                end
            end
        end
    end

    assign matchresult  = r_matchresult;
    assign result_valid = r_result_valid;
    assign p1_wins      = r_p1_wins;
    assign p2_wins      = r_p2_wins;
    assign draws        = r_draws;

endmodule

// File: tb/tb_card_compare.sv
// tb/tb_card_compare.sv - directed self-checking bench for card_compare
module tb_card_compare;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [3:0]       p1_handcard;
    logic [3:0]       p2_handcard;
    logic [1:0]       matchresult;
    logic             result_valid;
    logic [CNT_W-1:0] p1_wins;
    logic [CNT_W-1:0] p2_wins;
    logic [CNT_W-1:0] draws;

    int vectors_applied;
    int miscompares;

    card_compare #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .p1_handcard  (p1_handcard),
        .p2_handcard  (p2_handcard),
        .matchresult  (matchresult),
        .result_valid (result_valid),
        .p1_wins      (p1_wins),
        .p2_wins      (p2_wins),
        .draws        (draws)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors_applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [1:0] mr, input logic rv,
                               input int w1, input int w2, input int dr);
        check_eq({tag, ".matchresult"}, 32'(matchresult), 32'(mr));
        check_eq({tag, ".result_valid"}, 32'(result_valid), 32'(rv));
        check_eq({tag, ".p1_wins"}, 32'(p1_wins), w1);
        check_eq({tag, ".p2_wins"}, 32'(p2_wins), w2);
        check_eq({tag, ".draws"}, 32'(draws), dr);
    endtask

    logic [3:0] dir_p1 [6];
    logic [3:0] dir_p2 [6];
    logic [1:0] dir_res [6];

    initial begin
        vectors_applied = 0;
        miscompares     = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        p1_handcard = 4'd0;
        p2_handcard = 4'd0;

        dir_p1[0] = 4'b0000; dir_p2[0] = 4'b0000; dir_res[0] = 2'b01;
        dir_p1[1] = 4'b0010; dir_p2[1] = 4'b0001; dir_res[1] = 2'b10;
        dir_p1[2] = 4'b0100; dir_p2[2] = 4'b1000; dir_res[2] = 2'b11;
        dir_p1[3] = 4'b0111; dir_p2[3] = 4'b0111; dir_res[3] = 2'b01;
        dir_p1[4] = 4'b1111; dir_p2[4] = 4'b0000; dir_res[4] = 2'b10;
        dir_p1[5] = 4'b0000; dir_p2[5] = 4'b1111; dir_res[5] = 2'b11;

        // reset then idle
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_state("reset_idle", 2'b00, 1'b0, 0, 0, 0);

        // directed outcomes back-to-back
        for (int i = 0; i < 6; i++) begin
            in_valid    = 1'b1;
            p1_handcard = dir_p1[i];
            p2_handcard = dir_p2[i];
            tick();
            check_eq($sformatf("dir%0d.matchresult", i), 32'(matchresult), 32'(dir_res[i]));
            check_eq($sformatf("dir%0d.result_valid", i), 32'(result_valid), 32'd1);
        end
        check_eq("dir.p1_wins", 32'(p1_wins), 32'd2);
        check_eq("dir.p2_wins", 32'(p2_wins), 32'd2);
        check_eq("dir.draws", 32'(draws), 32'd2);

        // hold: P1 win then idle with changing/unknown card inputs
        p1_handcard = 4'b1111;
        p2_handcard = 4'b0000;
        tick();
        check_state("hold_load", 2'b10, 1'b1, 3, 2, 2);
        in_valid    = 1'b0;
        p2_handcard = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            p1_handcard = (i == 1) ? 4'bxxxx : 4'(i);
            tick();
            check_state($sformatf("hold%0d", i), 2'b10, 1'b0, 3, 2, 2);
        end

        // exhaustive sweep from fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [1:0] exp_r;
                exp_r = (a == b) ? 2'b01 : ((a > b) ? 2'b10 : 2'b11);
                in_valid    = 1'b1;
                p1_handcard = 4'(a);
                p2_handcard = 4'(b);
                tick();
                check_eq($sformatf("sweep_%0d_%0d", a, b), 32'(matchresult), 32'(exp_r));
                check_eq($sformatf("sweep_%0d_%0d.rv", a, b), 32'(result_valid), 32'd1);
            end
        end
        check_eq("sweep.p1_wins", 32'(p1_wins), 32'd120);
        check_eq("sweep.p2_wins", 32'(p2_wins), 32'd120);
        check_eq("sweep.draws", 32'(draws), 32'd16);

        // saturation
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            in_valid    = 1'b1;
            p1_handcard = 4'd15;
            p2_handcard = 4'(i % 15);
            tick();
            if (i == 253) check_eq("sat.p1_wins_254", 32'(p1_wins), 32'd254);
            if (i == 254) check_eq("sat.p1_wins_255", 32'(p1_wins), 32'd255);
        end
        check_state("sat_end", 2'b10, 1'b1, 255, 0, 0);

        // reset mid-stream with a valid pair in the reset cycle
        rst         = 1'b1;
        in_valid    = 1'b1;
        p1_handcard = 4'b0010;
        p2_handcard = 4'b0001;
        tick();
        check_state("mid_rst", 2'b00, 1'b0, 0, 0, 0);
        rst         = 1'b0;
        p1_handcard = 4'b0001;
        p2_handcard = 4'b0010;
        tick();
        check_state("post_rst", 2'b11, 1'b1, 0, 1, 0);
        in_valid = 1'b0;
        tick();
        check_state("post_rst_idle", 2'b11, 1'b0, 0, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
